// File: rtl/mul_rr_sched.sv
// Round-robin scheduler that feeds one pipelined unsigned multiplier, built from
// recursively composed 2x2 Vedic cells, from N_REQ valid/ready requesters.

module mul_rr_vedic #(
    parameter int W = 2
) (
    input  logic [W-1:0]   a,
    input  logic [W-1:0]   b,
    output logic [2*W-1:0] p
);
    localparam int H = W / 2;

    generate
        if (W == 2) begin : g_cell
            logic c1;
            assign c1   = (a[1] & b[0]) & (a[0] & b[1]);
            assign p[0] = a[0] & b[0];
            assign p[1] = (a[1] & b[0]) ^ (a[0] & b[1]);
            assign p[2] = (a[1] & b[1]) ^ c1;
            assign p[3] = (a[1] & b[1]) & c1;
        end else begin : g_tree
            logic [W-1:0] ll, lh, hl, hh;
            mul_rr_vedic #(.W(H)) u_ll (.a(a[H-1:0]), .b(b[H-1:0]), .p(ll));
            mul_rr_vedic #(.W(H)) u_lh (.a(a[H-1:0]), .b(b[W-1:H]), .p(lh));
            mul_rr_vedic #(.W(H)) u_hl (.a(a[W-1:H]), .b(b[H-1:0]), .p(hl));
            mul_rr_vedic #(.W(H)) u_hh (.a(a[W-1:H]), .b(b[W-1:H]), .p(hh));
            // Cross terms sit at weight 2^H; the exact product always fits in 2W bits.
            assign p = {hh, ll} + {{H{1'b0}}, lh, {H{1'b0}}} + {{H{1'b0}}, hl, {H{1'b0}}};
        end
    endgenerate
endmodule

module mul_rr_sched #(
    parameter int N_REQ = 4,
    parameter int W     = 8,
    parameter int LAT   = 2,
    parameter int IDW   = $clog2(N_REQ)
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic [N_REQ-1:0]   req_valid,
    input  logic [N_REQ*W-1:0] req_a,
    input  logic [N_REQ*W-1:0] req_b,
    output logic [N_REQ-1:0]   req_ready,
    output logic               res_valid,
    output logic [IDW-1:0]     res_id,
    output logic [2*W-1:0]     res_p,
    input  logic               res_ready,
    output logic               idle
);
    logic [LAT:1]                vld_pipe;
    logic [LAT:1][IDW-1:0]       id_pipe;
    logic [LAT:1][2*W-1:0]       p_pipe;
    logic [IDW-1:0]              ptr, win, idx;
    logic                        found, adv, acc;
    logic [W-1:0]                a_sel, b_sel;
    logic [2*W-1:0]              p_new;

    assign res_valid = vld_pipe[LAT];
    assign res_id    = id_pipe[LAT];
    assign res_p     = p_pipe[LAT];
    assign idle      = ~|vld_pipe;
    assign adv       = !res_valid || res_ready;

    // Search starts at ptr; N_REQ is a power of two so index wrap is free.
    always_comb begin
        found = 1'b0;
        win   = '0;
        idx   = '0;
        for (int k = 0; k < N_REQ; k++) begin
            idx = ptr + IDW'(k);
            if (!found && req_valid[idx]) begin
                found = 1'b1;
                win   = idx;
            end
        end
    end

    always_comb begin
        req_ready = '0;
        if (found && adv && rst_n)
            req_ready[win] = 1'b1;
    end

    assign acc   = |(req_valid & req_ready);
    assign a_sel = req_a[int'(win)*W +: W];
    assign b_sel = req_b[int'(win)*W +: W];

    mul_rr_vedic #(.W(W)) u_mul (.a(a_sel), .b(b_sel), .p(p_new));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            vld_pipe <= '0;
            id_pipe  <= '0;
            p_pipe   <= '0;
            ptr      <= '0;
        end else begin
            if (acc)
                ptr <= (win == IDW'(N_REQ - 1)) ? '0 : win + 1'b1;
            if (adv) begin
                vld_pipe[1] <= acc;
                id_pipe[1]  <= win;
                p_pipe[1]   <= p_new;
                for (int s = 2; s <= LAT; s++) begin
                    vld_pipe[s] <= vld_pipe[s-1];
                    id_pipe[s]  <= id_pipe[s-1];
                    p_pipe[s]   <= p_pipe[s-1];
                end
            end
        end
    end
endmodule

// File: tb/tb_mul_rr_sched.sv
// Directed bench for mul_rr_sched (N_REQ=4, W=8, LAT=2): arbitration order,
// products, backpressure freeze and asynchronous reset mid-flight.

module tb_mul_rr_sched;
    localparam int N = 4, W = 8, LAT = 2, IDW = 2;

    logic           clk = 1'b0;
    logic           rst_n;
    logic [N-1:0]   req_valid;
    logic [N*W-1:0] req_a, req_b;
    logic [N-1:0]   req_ready;
    logic           res_valid;
    logic [IDW-1:0] res_id;
    logic [2*W-1:0] res_p;
    logic           res_ready;
    logic           idle;

    int n_chk  = 0;
    int n_fail = 0;

    mul_rr_sched #(.N_REQ(N), .W(W), .LAT(LAT)) dut (
        .clk(clk), .rst_n(rst_n), .req_valid(req_valid), .req_a(req_a), .req_b(req_b),
        .req_ready(req_ready), .res_valid(res_valid), .res_id(res_id), .res_p(res_p),
        .res_ready(res_ready), .idle(idle)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    task automatic set_ops(input int i, input int a, input int b);
        req_a[i*W +: W] = W'(a);
        req_b[i*W +: W] = W'(b);
    endtask

    task automatic chk_res(input string tag, input int id, input int p);
        chk({tag, "_vld"}, 32'(res_valid), 32'd1);
        chk({tag, "_id"},  32'(res_id),    32'(id));
        chk({tag, "_p"},   32'(res_p),     32'(p));
    endtask

    task automatic pulse_reset();
        rst_n = 1'b0;
        #1;
        rst_n = 1'b1;
        tick();
    endtask

    int a_tab[4] = '{0, 1, 128, 170};
    int b_tab[4] = '{200, 1, 2, 85};
    int p_tab[4] = '{0, 1, 256, 14450};

    initial begin
        rst_n     = 1'b1;
        req_valid = '0;
        req_a     = '0;
        req_b     = '0;
        res_ready = 1'b1;
        #1 rst_n  = 1'b0;
        req_valid = 4'hf;
        #1;
        chk("rst_vld",  32'(res_valid), 32'd0);
        chk("rst_idle", 32'(idle),      32'd1);
        chk("rst_id",   32'(res_id),    32'd0);
        chk("rst_p",    32'(res_p),     32'd0);
        chk("rst_rdy",  32'(req_ready), 32'd0);
        tick();
        tick();
        req_valid = '0;
        rst_n     = 1'b1;

        // Single request: 255*255
        set_ops(0, 255, 255);
        req_valid = 4'b0001;
        #1 chk("single_gnt", 32'(req_ready), 32'd1);
        tick();
        req_valid = '0;
        #1;
        chk("single_lat_vld", 32'(res_valid), 32'd0);
        chk("single_busy",    32'(idle),      32'd0);
        tick();
        chk_res("single", 0, 65025);
        chk("single_busy2", 32'(idle), 32'd0);
        tick();
        chk("single_done_vld",  32'(res_valid), 32'd0);
        chk("single_done_idle", 32'(idle),      32'd1);

        // Full round-robin stream from ptr=0: A=i+1, B=3
        pulse_reset();
        for (int i = 0; i < N; i++) set_ops(i, i + 1, 3);
        for (int k = 0; k < 10; k++) begin
            req_valid = (k < 8) ? 4'hf : 4'h0;
            #1;
            if (k < 8) chk($sformatf("rr_gnt%0d", k), 32'(req_ready), 32'(1 << (k % 4)));
            if (k >= 2) chk_res($sformatf("rr_res%0d", k), (k - 2) % 4, 3 * ((k - 2) % 4 + 1));
            tick();
        end
        chk("rr_drain_vld",  32'(res_valid), 32'd0);
        chk("rr_drain_idle", 32'(idle),      32'd1);

        // Fairness: only 1 and 3 valid, ptr wrapped back to 0
        for (int k = 0; k < 4; k++) begin
            req_valid = 4'b1010;
            #1 chk($sformatf("fair_gnt%0d", k), 32'(req_ready), (k % 2 == 0) ? 32'd2 : 32'd8);
            tick();
        end
        req_valid = '0;
        tick();
        tick();
        chk("fair_idle", 32'(idle), 32'd1);

        // Backpressure: products 20,22,24,26
        for (int i = 0; i < N; i++) set_ops(i, 10 + i, 2);
        req_valid = 4'hf;
        #1 chk("bp_gnt0", 32'(req_ready), 32'd1);
        tick();
        #1 chk("bp_gnt1", 32'(req_ready), 32'd2);
        tick();
        res_ready = 1'b0;
        for (int k = 0; k < 3; k++) begin
            #1;
            chk($sformatf("bp_stall_rdy%0d", k), 32'(req_ready), 32'd0);
            chk_res($sformatf("bp_stall%0d", k), 0, 20);
            tick();
        end
        res_ready = 1'b1;
        #1;
        chk_res("bp_rel0", 0, 20);
        chk("bp_gnt2", 32'(req_ready), 32'd4);
        tick();
        #1;
        chk_res("bp_rel1", 1, 22);
        chk("bp_gnt3", 32'(req_ready), 32'd8);
        tick();
        req_valid = '0;
        #1 chk_res("bp_rel2", 2, 24);
        tick();
        chk_res("bp_rel3", 3, 26);
        tick();
        chk("bp_drain_vld", 32'(res_valid), 32'd0);

        // Boundary operands, ptr back at 0
        for (int i = 0; i < N; i++) set_ops(i, a_tab[i], b_tab[i]);
        for (int k = 0; k < 6; k++) begin
            req_valid = (k < 4) ? 4'hf : 4'h0;
            #1;
            if (k < 4) chk($sformatf("bnd_gnt%0d", k), 32'(req_ready), 32'(1 << k));
            if (k >= 2) chk_res($sformatf("bnd_res%0d", k - 2), k - 2, p_tab[k-2]);
            tick();
        end

        // Reset with two requests in flight
        for (int i = 0; i < N; i++) set_ops(i, i + 1, 3);
        req_valid = 4'hf;
        tick();
        tick();
        rst_n     = 1'b0;
        req_valid = 4'b1100;
        #1;
        chk("mid_rst_vld",  32'(res_valid), 32'd0);
        chk("mid_rst_idle", 32'(idle),      32'd1);
        chk("mid_rst_p",    32'(res_p),     32'd0);
        #1 rst_n = 1'b1;
        #1 chk("post_rst_gnt", 32'(req_ready), 32'd4);
        tick();
        req_valid = '0;
        #1 chk("post_rst_nostale", 32'(res_valid), 32'd0);
        tick();
        chk_res("post_rst", 2, 9);
        tick();
        chk("post_rst_idle", 32'(idle), 32'd1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
